// File: rtl/gf180mcu_fd_io__pwr_seq.sv
// Pad-ring power sequencer: synchronises and debounces per-segment supply-good flags,
// releases segment enables in order, powers down in reverse and latches segment faults.
module gf180mcu_fd_io__pwr_seq #(
    parameter int NSEG        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 100,
    parameter int STAGE_DLY   = 16,
    parameter int PG_TMO      = 4096
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [NSEG-1:0] PG_IN,
    input  logic            EN,
    input  logic            CLR_FAULT,
    output logic [NSEG-1:0] SEG_EN,
    output logic            READY,
    output logic            FAULT,
    output logic [NSEG-1:0] FAULT_SEG
);

    localparam int DEB_W = $clog2(DEB_CNT) + 1;
    localparam int TMO_W = $clog2(PG_TMO - 1) + 1;
    localparam int DLY_W = $clog2(STAGE_DLY - 1) + 1;
    localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    localparam logic [DLY_W-1:0] DLY_RELOAD = DLY_W'(STAGE_DLY - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(PG_TMO - 1);
    localparam logic [DEB_W-1:0] DEB_FULL   = DEB_W'(DEB_CNT);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NSEG - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_PG = 3'd1,
        STAGE   = 3'd2,
        ON      = 3'd3,
        DOWN    = 3'd4,
        FLT     = 3'd5
    } state_e;

    logic [NSEG-1:0]  sync_q [SYNC_STAGES];
    logic [DEB_W-1:0] deb_q  [NSEG];
    logic [DEB_W-1:0] deb_d  [NSEG];
    logic [NSEG-1:0]  pg_s;
    logic [NSEG-1:0]  pg_ok;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [NSEG-1:0]  seg_en_q, seg_en_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic [NSEG-1:0]  fault_seg_q, fault_seg_d;

    logic [NSEG-1:0]  flt_vec;
    logic [IDX_W-1:0] hi_idx;
    logic             any_en;
    logic             go_down;

    assign pg_s = sync_q[SYNC_STAGES-1];

    // Rise is slow (counter must saturate), fall is immediate (counter clears).
    always_comb begin
        for (int i = 0; i < NSEG; i++) begin
            if (!pg_s[i])
                deb_d[i] = '0;
            else if (deb_q[i] == DEB_FULL)
                deb_d[i] = deb_q[i];
            else
                deb_d[i] = deb_q[i] + 1'b1;
            pg_ok[i] = (deb_q[i] == DEB_FULL);
        end
    end

    // SEG_EN is a thermometer code, so the highest set bit is the last segment powered.
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < NSEG; i++)
            if (seg_en_q[i]) hi_idx = IDX_W'(i);
        any_en  = |seg_en_q;
        flt_vec = seg_en_q & ~pg_ok;
    end

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        dly_d       = dly_q;
        seg_en_d    = seg_en_q;
        ready_d     = ready_q;
        fault_d     = fault_q;
        fault_seg_d = fault_seg_q;
        go_down     = 1'b0;

        if (state_q != IDLE && state_q != FLT && |flt_vec) begin
            state_d     = FLT;
            seg_en_d    = '0;
            ready_d     = 1'b0;
            fault_d     = 1'b1;
            fault_seg_d = fault_seg_q | flt_vec;
        end else begin
            unique case (state_q)
                IDLE: if (EN) begin
                    state_d = WAIT_PG;
                    idx_d   = '0;
                    tmo_d   = '0;
                end
                WAIT_PG: begin
                    if (!EN) begin
                        go_down = 1'b1;
                    end else if (pg_ok[idx_q]) begin
                        seg_en_d[idx_q] = 1'b1;
                        dly_d           = DLY_RELOAD;
                        state_d         = STAGE;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d            = FLT;
                        seg_en_d           = '0;
                        ready_d            = 1'b0;
                        fault_d            = 1'b1;
                        fault_seg_d[idx_q] = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                STAGE: begin
                    if (!EN) begin
                        go_down = 1'b1;
                    end else if (dly_q != '0) begin
                        dly_d = dly_q - 1'b1;
                    end else if (idx_q < IDX_LAST) begin
                        idx_d   = idx_q + 1'b1;
                        tmo_d   = '0;
                        state_d = WAIT_PG;
                    end else begin
                        state_d = ON;
                        ready_d = 1'b1;
                    end
                end
                ON: if (!EN) go_down = 1'b1;
                DOWN: begin
                    if (EN) begin
                        state_d = WAIT_PG;
                        idx_d   = any_en ? hi_idx + 1'b1 : '0;
                        tmo_d   = '0;
                    end else if (dly_q != '0) begin
                        dly_d = dly_q - 1'b1;
                    end else if (!any_en) begin
                        state_d = IDLE;
                    end else begin
                        seg_en_d[hi_idx] = 1'b0;
                        idx_d            = (hi_idx == '0) ? '0 : hi_idx - 1'b1;
                        dly_d            = DLY_RELOAD;
                    end
                end
                FLT: if (CLR_FAULT && !EN) begin
                    state_d     = IDLE;
                    fault_d     = 1'b0;
                    fault_seg_d = '0;
                end
                default: state_d = IDLE;
            endcase

            // Power-down entry drops the highest live segment in the same edge.
            if (go_down) begin
                ready_d = 1'b0;
                if (!any_en) begin
                    state_d = IDLE;
                end else begin
                    state_d          = DOWN;
                    seg_en_d[hi_idx] = 1'b0;
                    idx_d            = (hi_idx == '0) ? '0 : hi_idx - 1'b1;
                    dly_d            = DLY_RELOAD;
                end
            end
        end
    end

    // NOTE: all state uses non-blocking assignments; reset clears the small synchroniser
    // and debounce arrays too, since they are flops, not RAM.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < NSEG; i++) deb_q[i] <= '0;
            state_q     <= IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            dly_q       <= '0;
            seg_en_q    <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            fault_seg_q <= '0;
        end else begin
            sync_q[0] <= PG_IN;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < NSEG; i++) deb_q[i] <= deb_d[i];
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            dly_q       <= dly_d;
            seg_en_q    <= seg_en_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            fault_seg_q <= fault_seg_d;
        end
    end

    assign SEG_EN    = seg_en_q;
    assign READY     = ready_q;
    assign FAULT     = fault_q;
    assign FAULT_SEG = fault_seg_q;

endmodule

// File: tb/tb_gf180mcu_fd_io__pwr_seq.sv
// Directed bench for the pad-ring power sequencer (NSEG=4, DEB_CNT=4, STAGE_DLY=3, PG_TMO=20).
module tb_gf180mcu_fd_io__pwr_seq;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic [3:0] PG_IN;
    logic       EN;
    logic       CLR_FAULT;
    logic [3:0] SEG_EN;
    logic       READY;
    logic       FAULT;
    logic [3:0] FAULT_SEG;

    int n_checks = 0;
    int n_fail   = 0;

    gf180mcu_fd_io__pwr_seq #(
        .NSEG(4), .SYNC_STAGES(2), .DEB_CNT(4), .STAGE_DLY(3), .PG_TMO(20)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .PG_IN(PG_IN), .EN(EN), .CLR_FAULT(CLR_FAULT),
        .SEG_EN(SEG_EN), .READY(READY), .FAULT(FAULT), .FAULT_SEG(FAULT_SEG)
    );

    always #5 CLK = ~CLK;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0; PG_IN = 4'hF; EN = 1'b0; CLR_FAULT = 1'b0;
        tick(3);
        if ({SEG_EN, READY, FAULT, FAULT_SEG} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got SEG_EN=%h READY=%b FAULT=%b FAULT_SEG=%h, want all 0",
                     SEG_EN, READY, FAULT, FAULT_SEG);
        end
        n_checks++;
        RSTN = 1'b1;
        tick(8);
        if (dut.state_q !== 3'd0 || SEG_EN !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got state=%0d SEG_EN=%h, want 0 and 0", dut.state_q, SEG_EN);
        end
        n_checks++;
    endtask

    task automatic test_seq_up(input string tag);
        logic [3:0] prev;
        logic [3:0] exp;
        EN = 1'b1;
        tick(1);
        if (SEG_EN !== 4'h0) begin
            n_fail++;
            $display("FAIL %s_wait_pg: SEG_EN=%h want 0", tag, SEG_EN);
        end
        n_checks++;
        tick(1);
        if (SEG_EN !== 4'h1 || FAULT !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_seg0: SEG_EN=%h FAULT=%b want 1 and 0", tag, SEG_EN, FAULT);
        end
        n_checks++;
        prev = 4'h1;
        for (int s = 1; s < 4; s++) begin
            exp = {prev[2:0], 1'b1};
            tick(3);
            if (SEG_EN !== prev) begin
                n_fail++;
                $display("FAIL %s_hold%0d: SEG_EN=%h want %h", tag, s, SEG_EN, prev);
            end
            n_checks++;
            tick(1);
            if (SEG_EN !== exp || FAULT !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_step%0d: SEG_EN=%h FAULT=%b want %h and 0", tag, s, SEG_EN, FAULT, exp);
            end
            n_checks++;
            prev = exp;
        end
        tick(2);
        if (READY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready_early: READY=%b want 0", tag, READY);
        end
        n_checks++;
        tick(1);
        if (READY !== 1'b1 || SEG_EN !== 4'hF || FAULT !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready: READY=%b SEG_EN=%h FAULT=%b want 1, F, 0", tag, READY, SEG_EN, FAULT);
        end
        n_checks++;
    endtask

    task automatic test_seq_down();
        logic [3:0] steps [3] = '{4'h3, 4'h1, 4'h0};
        logic [3:0] prev;
        EN = 1'b0;
        tick(1);
        if (SEG_EN !== 4'h7 || READY !== 1'b0) begin
            n_fail++;
            $display("FAIL down_first: SEG_EN=%h READY=%b want 7 and 0", SEG_EN, READY);
        end
        n_checks++;
        prev = 4'h7;
        for (int s = 0; s < 3; s++) begin
            tick(2);
            if (SEG_EN !== prev) begin
                n_fail++;
                $display("FAIL down_hold%0d: SEG_EN=%h want %h", s, SEG_EN, prev);
            end
            n_checks++;
            tick(1);
            if (SEG_EN !== steps[s]) begin
                n_fail++;
                $display("FAIL down_step%0d: SEG_EN=%h want %h", s, SEG_EN, steps[s]);
            end
            n_checks++;
            prev = steps[s];
        end
        tick(2);
        if (dut.state_q !== 3'd4) begin
            n_fail++;
            $display("FAIL down_linger: state=%0d want 4 (DOWN)", dut.state_q);
        end
        n_checks++;
        tick(1);
        if (dut.state_q !== 3'd0) begin
            n_fail++;
            $display("FAIL down_idle: state=%0d want 0 (IDLE)", dut.state_q);
        end
        n_checks++;
        test_seq_up("reseq");
    endtask

    task automatic test_timeout();
        EN = 1'b0;
        tick(14);
        if (dut.state_q !== 3'd0) begin
            n_fail++;
            $display("FAIL tmo_start_idle: state=%0d want 0", dut.state_q);
        end
        n_checks++;
        PG_IN = 4'h7;
        EN    = 1'b1;
        // WAIT_PG for segment 3 is entered 13 edges after EN; timeout 20 edges later.
        tick(32);
        if (SEG_EN !== 4'h7 || FAULT !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_before: SEG_EN=%h FAULT=%b want 7 and 0", SEG_EN, FAULT);
        end
        n_checks++;
        tick(1);
        if (FAULT !== 1'b1 || FAULT_SEG !== 4'h8 || SEG_EN !== 4'h0 || READY !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_fault: FAULT=%b FAULT_SEG=%h SEG_EN=%h READY=%b want 1, 8, 0, 0",
                     FAULT, FAULT_SEG, SEG_EN, READY);
        end
        n_checks++;
        EN = 1'b0; CLR_FAULT = 1'b1;
        tick(1);
        CLR_FAULT = 1'b0;
        if (FAULT !== 1'b0 || FAULT_SEG !== 4'h0) begin
            n_fail++;
            $display("FAIL tmo_clear: FAULT=%b FAULT_SEG=%h want 0 and 0", FAULT, FAULT_SEG);
        end
        n_checks++;
    endtask

    task automatic test_live_fault();
        PG_IN = 4'hF;
        tick(8);
        EN = 1'b1;
        tick(20);
        if (READY !== 1'b1 || SEG_EN !== 4'hF) begin
            n_fail++;
            $display("FAIL live_on: READY=%b SEG_EN=%h want 1 and F", READY, SEG_EN);
        end
        n_checks++;
        PG_IN = 4'hD;
        tick(3);
        if (SEG_EN !== 4'hF || FAULT !== 1'b0) begin
            n_fail++;
            $display("FAIL live_latency: SEG_EN=%h FAULT=%b want F and 0", SEG_EN, FAULT);
        end
        n_checks++;
        PG_IN = 4'hF;
        tick(1);
        if (SEG_EN !== 4'h0 || FAULT !== 1'b1 || FAULT_SEG !== 4'h2 || READY !== 1'b0) begin
            n_fail++;
            $display("FAIL live_fault: SEG_EN=%h FAULT=%b FAULT_SEG=%h READY=%b want 0, 1, 2, 0",
                     SEG_EN, FAULT, FAULT_SEG, READY);
        end
        n_checks++;
        CLR_FAULT = 1'b1;
        tick(2);
        if (FAULT !== 1'b1 || FAULT_SEG !== 4'h2) begin
            n_fail++;
            $display("FAIL live_sticky: FAULT=%b FAULT_SEG=%h want 1 and 2", FAULT, FAULT_SEG);
        end
        n_checks++;
        EN = 1'b0;
        tick(1);
        CLR_FAULT = 1'b0;
        if (FAULT !== 1'b0 || FAULT_SEG !== 4'h0 || dut.state_q !== 3'd0) begin
            n_fail++;
            $display("FAIL live_clear: FAULT=%b FAULT_SEG=%h state=%0d want 0, 0, 0",
                     FAULT, FAULT_SEG, dut.state_q);
        end
        n_checks++;
    endtask

    task automatic test_glitch();
        PG_IN = 4'h0;
        tick(4);
        EN = 1'b1;
        tick(2);
        PG_IN = 4'h1;
        tick(2);
        PG_IN = 4'h0;
        tick(6);
        if (SEG_EN !== 4'h0) begin
            n_fail++;
            $display("FAIL glitch_reject: SEG_EN=%h want 0", SEG_EN);
        end
        n_checks++;
        PG_IN = 4'h1;
        tick(6);
        if (SEG_EN !== 4'h0) begin
            n_fail++;
            $display("FAIL glitch_debounce: SEG_EN=%h want 0", SEG_EN);
        end
        n_checks++;
        tick(1);
        if (SEG_EN !== 4'h1 || FAULT !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_accept: SEG_EN=%h FAULT=%b want 1 and 0", SEG_EN, FAULT);
        end
        n_checks++;
    endtask

    task automatic test_async_reset();
        RSTN = 1'b0; PG_IN = 4'hF; EN = 1'b0;
        tick(2);
        RSTN = 1'b1;
        tick(8);
        EN = 1'b1;
        tick(6);
        if (SEG_EN !== 4'h3 || dut.state_q !== 3'd2) begin
            n_fail++;
            $display("FAIL arst_setup: SEG_EN=%h state=%0d want 3 and 2", SEG_EN, dut.state_q);
        end
        n_checks++;
        tick(1);
        #2;
        RSTN = 1'b0;
        #1;
        if ({SEG_EN, READY, FAULT, FAULT_SEG} !== 10'b0 || dut.state_q !== 3'd0) begin
            n_fail++;
            $display("FAIL arst_async: SEG_EN=%h READY=%b FAULT=%b FAULT_SEG=%h state=%0d want all 0",
                     SEG_EN, READY, FAULT, FAULT_SEG, dut.state_q);
        end
        n_checks++;
        EN = 1'b0;
        tick(1);
        RSTN = 1'b1;
        tick(8);
        if (dut.state_q !== 3'd0 || SEG_EN !== 4'h0) begin
            n_fail++;
            $display("FAIL arst_idle: state=%0d SEG_EN=%h want 0 and 0", dut.state_q, SEG_EN);
        end
        n_checks++;
        EN = 1'b1;
        tick(2);
        if (SEG_EN !== 4'h1) begin
            n_fail++;
            $display("FAIL arst_restart: SEG_EN=%h want 1", SEG_EN);
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_seq_up("up");
        test_seq_down();
        test_timeout();
        test_live_fault();
        test_glitch();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
